// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the RAM/IO responder: bus types, IO addresses, access decode.
package ram_io_responder_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [7:0]  ByteBus;

    localparam MemAddrBus   IO_BASE   = 32'h0003_0000;
    localparam MemAddrBus   IO_STATUS = 32'h0003_0004;
    localparam logic [15:0] IoPage    = 16'h0003;

    typedef enum logic [2:0] {
        AccRamRead,
        AccRamWrite,
        AccRxRead,
        AccStatusRead,
        AccTxWrite,
        AccHaltWrite,
        AccIoIgnore
    } access_e;

    function automatic access_e decode_access(input logic rw, input MemAddrBus addr);
        access_e acc;
        if (addr[31:16] != IoPage) begin
            acc = rw ? AccRamWrite : AccRamRead;
        end else if (addr == IO_BASE) begin
            acc = rw ? AccTxWrite : AccRxRead;
        end else if (addr == IO_STATUS) begin
            acc = rw ? AccHaltWrite : AccStatusRead;
        end else begin
            acc = AccIoIgnore;
        end
        return acc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    localparam ptr_t PtrOne  = ptr_t'(1);
    localparam cnt_t CntOne  = cnt_t'(1);
    localparam cnt_t CntFull = cnt_t'(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             count_q, count_d;
    logic             push_fire, pop_fire;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CntFull);
    assign head_o    = store_q[rd_ptr_q];
    assign pop_fire  = pop_i && !empty_o;
    assign push_fire = push_i && (!full_o || pop_fire);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + PtrOne;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push_fire && !reset) store_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM with a memory-mapped IO page: TX/RX byte FIFOs, status register and halt flag.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      ram_rw,
    input  MemAddrBus ram_addr,
    input  ByteBus    ram_w_data,
    output ByteBus    ram_r_data,
    output ByteBus    tx_data,
    output logic      tx_valid,
    input  logic      tx_ready,
    input  ByteBus    rx_data,
    input  logic      rx_valid,
    output logic      rx_ready,
    output logic      halt,
    output logic      tx_overflow
);

    localparam int unsigned RamBytes = 2 ** RAM_ADDR_WIDTH;

    ByteBus                    ram_q [RamBytes];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    access_e                   access;

    ByteBus r_data_q, rd_data;
    logic   halt_q, halt_d;
    logic   tx_overflow_q, tx_overflow_d;

    logic   tx_push, tx_pop, tx_empty, tx_full;
    logic   rx_push, rx_pop, rx_empty, rx_full;
    ByteBus rx_head;

    assign access  = decode_access(ram_rw, ram_addr);
    assign ram_idx = ram_addr[RAM_ADDR_WIDTH-1:0];

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_push  = (access == AccTxWrite) && !reset;
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = (access == AccRxRead) && !reset;

    always_comb begin
        rd_data = '0;
        case (access)
            AccRamRead:    rd_data = ram_q[ram_idx];
            AccRxRead:     rd_data = rx_empty ? '0 : rx_head;
            AccStatusRead: rd_data = {6'b0, ~rx_empty, tx_full};
            default:       rd_data = '0;
        endcase
    end

    always_comb begin
        halt_d        = halt_q | (access == AccHaltWrite);
        // A full TX still takes the byte if the consumer drains one this cycle.
        tx_overflow_d = tx_overflow_q | (tx_push && tx_full && !tx_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_q      <= '0;
            halt_q        <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            if (!ram_rw) r_data_q <= rd_data;
            halt_q        <= halt_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && access == AccRamWrite) ram_q[ram_idx] <= ram_w_data;
    end

    assign ram_r_data  = r_data_q;
    assign halt        = halt_q;
    assign tx_overflow = tx_overflow_q;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (tx_push),
        .push_data_i(ram_w_data),
        .pop_i      (tx_pop),
        .head_o     (tx_data),
        .empty_o    (tx_empty),
        .full_o     (tx_full)
    );

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (rx_push),
        .push_data_i(rx_data),
        .pop_i      (rx_pop),
        .head_o     (rx_head),
        .empty_o    (rx_empty),
        .full_o     (rx_full)
    );

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed and randomized bench for ram_io_responder against a queue-based reference model.
module tb_ram_io_responder;

    localparam int DEPTH = 8;
    localparam logic [31:0] IoBase   = 32'h0003_0000;
    localparam logic [31:0] IoStatus = 32'h0003_0004;
    localparam logic [31:0] IoOther  = 32'h0003_0008;

    logic        clock = 1'b0;
    logic        reset, ram_rw, tx_ready, rx_valid;
    logic [31:0] ram_addr;
    logic [7:0]  ram_w_data, rx_data;
    logic [7:0]  ram_r_data, tx_data;
    logic        tx_valid, rx_ready, halt, tx_overflow;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] ram_m [int unsigned];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_r;
    logic       r_known;
    logic       exp_halt, exp_ovf;

    ram_io_responder #(
        .RAM_ADDR_WIDTH(17),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_w_data (ram_w_data),
        .ram_r_data (ram_r_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .halt       (halt),
        .tx_overflow(tx_overflow)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Applies the rules of one rising edge to the model, using the inputs seen at that edge.
    task automatic model_edge();
        logic       io, tx_pop, tx_push, rx_pop, rx_push;
        logic [7:0] rd;
        int unsigned idx;
        if (reset) begin
            exp_r = 8'h00; r_known = 1'b1; exp_halt = 1'b0; exp_ovf = 1'b0;
            tx_q.delete(); rx_q.delete();
            return;
        end
        io      = (ram_addr[31:16] == 16'h0003);
        idx     = int'(ram_addr[16:0]);
        tx_pop  = (tx_q.size() != 0) && tx_ready;
        rx_push = rx_valid && (rx_q.size() < DEPTH);
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        if (!ram_rw) begin
            rd = 8'h00;
            r_known = 1'b1;
            if (!io) begin
                if (ram_m.exists(idx)) rd = ram_m[idx];
                else r_known = 1'b0;
            end else if (ram_addr == IoBase) begin
                if (rx_q.size() != 0) begin rd = rx_q[0]; rx_pop = 1'b1; end
            end else if (ram_addr == IoStatus) begin
                rd = {6'b0, rx_q.size() != 0, tx_q.size() == DEPTH};
            end
            exp_r = rd;
        end else begin
            if (!io) ram_m[idx] = ram_w_data;
            else if (ram_addr == IoBase) begin
                if (tx_q.size() < DEPTH || tx_pop) tx_push = 1'b1;
                else exp_ovf = 1'b1;
            end else if (ram_addr == IoStatus) exp_halt = 1'b1;
        end
        if (tx_pop)  void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(ram_w_data);
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rx_data);
    endtask

    task automatic check_outputs();
        if (r_known) chk("ram_r_data", ram_r_data, exp_r);
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, tx_q.size() != 0});
        if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
        chk("rx_ready", {7'b0, rx_ready}, {7'b0, rx_q.size() < DEPTH});
        chk("halt", {7'b0, halt}, {7'b0, exp_halt});
        chk("tx_overflow", {7'b0, tx_overflow}, {7'b0, exp_ovf});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic access(input logic rw, input logic [31:0] addr, input logic [7:0] wd);
        ram_rw = rw; ram_addr = addr; ram_w_data = wd;
    endtask

    // Idle is a harmless read of an unmapped IO address.
    task automatic idle();
        access(1'b0, IoOther, 8'h00);
    endtask

    initial begin
        logic [31:0] ram_set [6];
        ram_set[0] = 32'h0000_0100; ram_set[1] = 32'h0004_0100; ram_set[2] = 32'h0001_FFFF;
        ram_set[3] = 32'h0000_0000; ram_set[4] = 32'h0001_0000; ram_set[5] = 32'hFFFF_0200;

        r_known = 1'b0; exp_r = 8'h00; exp_halt = 1'b0; exp_ovf = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        reset = 1'b1;
        access(1'b1, 32'h0000_0100, 8'h77);  // must be ignored under reset
        step(); step();
        chk("reset r_data", ram_r_data, 8'h00);
        chk("reset tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("reset rx_ready", {7'b0, rx_ready}, 8'h01);
        chk("reset halt", {7'b0, halt}, 8'h00);
        chk("reset overflow", {7'b0, tx_overflow}, 8'h00);
        reset = 1'b0;

        // RAM write then read-back
        access(1'b1, 32'h0000_0100, 8'hA5); step();
        access(1'b0, 32'h0000_0100, 8'h00); step();
        chk("ram readback", ram_r_data, 8'hA5);
        access(1'b1, 32'h0000_0100, 8'h3C); step();
        chk("r_data held on write", ram_r_data, 8'hA5);
        access(1'b1, 32'h0000_0100, 8'hA5); step();
        idle(); step();

        // "Hi" on TX
        access(1'b1, IoBase, 8'h48); step();
        access(1'b1, IoBase, 8'h69); step();
        idle(); step();
        chk("tx H", tx_data, 8'h48);
        tx_ready = 1'b1; step();
        chk("tx i", tx_data, 8'h69);
        step();
        chk("tx drained", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // Full TX with same-cycle pop accepts the byte
        for (int i = 0; i < DEPTH; i++) begin access(1'b1, IoBase, 8'h80 + 8'(i)); step(); end
        tx_ready = 1'b1; access(1'b1, IoBase, 8'hEE); step();
        chk("full+pop no overflow", {7'b0, tx_overflow}, 8'h00);
        chk("full+pop head", tx_data, 8'h81);
        idle();
        for (int i = 0; i < DEPTH; i++) step();
        chk("full+pop drained", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // Nine writes into depth-8 TX
        for (int i = 0; i < 9; i++) begin access(1'b1, IoBase, 8'h40 + 8'(i)); step(); end
        chk("overflow set", {7'b0, tx_overflow}, 8'h01);
        access(1'b0, IoStatus, 8'h00); step();
        chk("status tx full", ram_r_data, 8'h01);
        idle(); tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("retained byte", tx_data, 8'h40 + 8'(i));
            step();
        end
        chk("overflow drained", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // RX path
        rx_valid = 1'b1; rx_data = 8'h11; step();
        rx_data = 8'h22; step();
        rx_valid = 1'b0;
        access(1'b0, IoStatus, 8'h00); step();
        chk("status rx", ram_r_data, 8'h02);
        access(1'b0, IoBase, 8'h00); step();
        chk("rx 1st", ram_r_data, 8'h11);
        step();
        chk("rx 2nd", ram_r_data, 8'h22);
        step();
        chk("rx empty", ram_r_data, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h33; step();
        chk("rx empty same-cycle push", ram_r_data, 8'h00);
        rx_valid = 1'b0; step();
        chk("rx late byte", ram_r_data, 8'h33);
        idle(); step();

        // Halt, then reset keeps RAM
        access(1'b1, IoStatus, 8'h00); step();
        chk("halt set", {7'b0, halt}, 8'h01);
        access(1'b1, 32'h0000_0200, 8'h5A); step();
        access(1'b0, 32'h0000_0200, 8'h00); step();
        chk("ram after halt", ram_r_data, 8'h5A);
        chk("halt sticky", {7'b0, halt}, 8'h01);
        reset = 1'b1; idle(); step();
        reset = 1'b0;
        chk("halt cleared", {7'b0, halt}, 8'h00);
        access(1'b0, 32'h0000_0100, 8'h00); step();
        chk("ram survives reset", ram_r_data, 8'hA5);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            reset    = ($urandom_range(0, 79) == 0);
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 1) == 0);
            rx_data  = 8'($urandom);
            sel      = $urandom_range(0, 9);
            case (sel)
                0, 1:    ram_addr = IoBase;
                2:       ram_addr = IoStatus;
                3:       ram_addr = 32'h0003_FFFC;
                default: ram_addr = ram_set[$urandom_range(0, 5)];
            endcase
            ram_rw     = ($urandom_range(0, 2) == 0);
            ram_w_data = 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_io_responder.md
RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, byte-address width of the internal RAM (2^17 bytes).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per TX/RX FIFO (power of two, >=2).
REQ-003 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port ram_rw, input, 1, 1 = write, 0 = read, sampled every cycle.
REQ-006 SHALL have port ram_addr, input, 32, byte address.
REQ-007 SHALL have port ram_w_data, input, 8, write byte.
REQ-008 SHALL have port ram_r_data, output, 8, registered read byte.
REQ-009 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1), the outgoing byte stream.
REQ-010 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1), the incoming byte stream.
REQ-011 SHALL have ports halt (output, 1, sticky program-end flag) and tx_overflow (output, 1, sticky dropped-TX-byte flag).

Function
REQ-012 SHALL decode IO space as ram_addr[31:16] == 16'h0003; all other addresses SHALL map to RAM byte ram_addr[RAM_ADDR_WIDTH-1:0], with upper bits ignored.
REQ-013 SHALL give every read exactly 1 cycle of latency: address presented in cycle N, ram_r_data valid throughout cycle N+1, then held until the next read.
REQ-014 SHALL perform a RAM write at the rising edge of any cycle with ram_rw=1; ram_r_data SHALL hold its previous value during write cycles.
REQ-015 SHALL make a read of an address written in the previous cycle return the new byte.
REQ-016 SHALL, on a read of 0x30000, return the RX FIFO head and pop it; when RX is empty it SHALL return 8'h00 with no pop, even if rx_valid pushes in the same cycle.
REQ-017 SHALL, on a read of 0x30004, return status {6'b0, rx_nonempty, tx_full}, reflecting state before the current edge.
REQ-018 SHALL, on a write of 0x30000, push ram_w_data into TX; when TX is full with no same-cycle pop, the byte SHALL be dropped and tx_overflow set.
REQ-019 SHALL, on a write of 0x30004, set halt (data ignored); subsequent RAM/IO accesses SHALL continue normally.
REQ-020 SHALL return 8'h00 for reads of other IO addresses and SHALL ignore writes to them.
REQ-021 SHALL drive tx_valid = TX non-empty and tx_data = TX head; a pop occurs on tx_valid && tx_ready.
REQ-022 SHALL drive rx_ready = RX not full; a push occurs on rx_valid && rx_ready.
REQ-023 SHALL accept a push into a full FIFO if a pop occurs in the same cycle; simultaneous push+pop on a non-empty FIFO SHALL leave the count unchanged.
REQ-024 SHALL use read/write pointers of log2(FIFO_DEPTH) bits wrapping modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits; FIFO order SHALL be strictly first-in first-out.

Reset
REQ-025 SHALL, on reset, clear ram_r_data, halt and tx_overflow to 0, empty both FIFOs (tx_valid=0, rx_ready=1), and ignore ram_rw/ram_addr in that cycle.
REQ-026 SHALL leave RAM contents unchanged by reset; reset mid-transfer SHALL discard all queued FIFO bytes.

Structure
REQ-027 SHALL place IO_BASE (32'h30000), IO_STATUS (32'h30004), MemAddrBus and ByteBus in the shared define file.
REQ-028 SHALL implement both FIFOs by instantiating one sub-module, sync_fifo (parameters WIDTH, DEPTH), twice.

Verification
REQ-029 SHALL verify: write 0xA5 to 0x00100, then read 0x00100 next cycle -> ram_r_data=0xA5 one cycle later.
REQ-030 SHALL verify: write 'H','i' to 0x30000 with tx_ready=0, then raise tx_ready -> tx_data 0x48 then 0x69, tx_valid falls after 2 pops.
REQ-031 SHALL verify: 9 writes to 0x30000 with tx_ready=0 (depth 8) -> 8 bytes retained, tx_overflow=1, status read=0x01.
REQ-032 SHALL verify: rx pushes 0x11,0x22, then read 0x30004 -> 0x02, then three reads of 0x30000 -> 0x11, 0x22, 0x00.
REQ-033 SHALL verify: write 0x30004 -> halt=1 next cycle and stays 1; reset -> halt=0, RAM byte at 0x00100 still 0xA5.
REQ-034 SHALL verify: TX full with tx_ready=1 and a same-cycle write -> byte accepted, tx_overflow stays 0.
